// File: rtl/conv_decoder_input_fifo.sv
// First-word-fall-through pixel FIFO with frame tagging: push-to-visible latency 1 cycle.
// in_ready drops only when full (no bypass); out_data holds steady while out_ready is low.
module conv_decoder_input_fifo #(
  parameter int DATA_W    = 18,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 64,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              frame_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int FC_W  = $clog2(FRAME_LEN) + 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FC_W-1:0]   fcnt;
  logic              push;
  logic              pop;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign out_last  = out_valid && (fcnt == FC_LAST);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage is deliberately left unreset; only the control state is cleared.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fcnt       <= '0;
      frame_done <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        fcnt   <= out_last ? '0 : fcnt + FC_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      frame_done <= pop && out_last;
    end
  end

endmodule
